// File: rtl/seven_seg_scan_controller_if.sv
// Producer-to-display handshake for seven_seg_scan_controller.
// master = word producer (SD readout datapath), slave = scan controller.
interface seven_seg_scan_controller_if;
  logic [15:0] valueIn;
  logic [3:0]  dpIn;
  logic        valueValid;
  logic        valueReady;

  modport master (
    output valueIn,
    output dpIn,
    output valueValid,
    input  valueReady
  );

  modport slave (
    input  valueIn,
    input  dpIn,
    input  valueValid,
    output valueReady
  );
endinterface

// File: rtl/seven_seg_scan_controller.sv
// Four-digit multiplexed seven-segment scan controller.
// Each digit slot lasts TICK_DIV cycles: BLANK_CYCLES of dead time (all anodes off),
// then the digit is driven. New words are buffered in a one-entry pending register and
// copied into the display word only when the scan wraps back into digit 0, so a frame
// never shows a mix of old and new nibbles. All outputs are registered and therefore
// trail the internal slot counter by one cycle.
// Optional feature macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN (leading-zero suppression on
// digits 3..1; digit 0 always shown, decimal points still driven).
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_BLANK | slotCount < BLANK_CYCLES: anodes off, cathodes off
// ST_DRIVE | rest of the slot: anode[digit] low, cathodes show the glyph
module seven_seg_scan_controller #(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                         cmosClock,
  input  logic                         reset,
  seven_seg_scan_controller_if.slave   value_if,
  output logic                         frameStart,
  output logic [3:0]                   sevenSegmentEnable,
  output logic [7:0]                   sevenSegmentData
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Segment pattern, active-high, {g,f,e,d,c,b,a}; b and d lowercase, 6/7/9 with tails.
  function automatic logic [6:0] hexseg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h27;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // True when digit d and every digit to its left hold zero; digit 0 is never suppressed.
  function automatic logic lead_zero(input logic [15:0] w, input logic [1:0] d);
    logic z;
    case (d)
      2'd3:    z = (w[15:12] == 4'h0);
      2'd2:    z = (w[15:8]  == 8'h00);
      2'd1:    z = (w[15:4]  == 12'h000);
      default: z = 1'b0;
    endcase
    return z;
  endfunction
`endif

  logic [CW-1:0] slot_q,       slot_d;
  logic [1:0]    digit_q,      digit_d;
  state_t        state_q,      state_d;
  logic [15:0]   disp_word_q,  disp_word_d;
  logic [3:0]    disp_dp_q,    disp_dp_d;
  logic [15:0]   pend_word_q,  pend_word_d;
  logic [3:0]    pend_dp_q,    pend_dp_d;
  logic          pend_full_q,  pend_full_d;
  logic          ready_q,      ready_d;
  logic          frame_start_q, frame_start_d;
  logic [3:0]    enable_q,     enable_d;
  logic [7:0]    data_q,       data_d;

  logic          slot_wrap;
  logic          accept;
  logic          commit;
  logic [3:0]    cur_nib;
  logic [6:0]    cur_seg;

  // Next-state logic: slot/digit sequencing, phase FSM, handshake, commit and output decode.
  always_comb begin
    slot_wrap   = (slot_q == SLOT_LAST);
    slot_d      = slot_wrap ? '0 : slot_q + CW'(1);
    digit_d     = slot_wrap ? digit_q + 2'd1 : digit_q;

    state_d = state_q;
    case (state_q)
      ST_BLANK: if (slot_q == BLANK_LAST) state_d = ST_DRIVE;
      ST_DRIVE: if (slot_wrap)            state_d = ST_BLANK;
      default:                            state_d = ST_BLANK;
    endcase

    // ready_q mirrors "pending empty", so accept and commit are mutually exclusive.
    accept = value_if.valueValid && ready_q;
    commit = slot_wrap && (digit_q == 2'd3) && pend_full_q;

    pend_word_d = pend_word_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    disp_word_d = disp_word_q;
    disp_dp_d   = disp_dp_q;
    if (accept) begin
      pend_word_d = value_if.valueIn;
      pend_dp_d   = value_if.dpIn;
      pend_full_d = 1'b1;
    end else if (commit) begin
      disp_word_d = pend_word_q;
      disp_dp_d   = pend_dp_q;
      pend_full_d = 1'b0;
    end
    ready_d = ~pend_full_d;

    cur_nib = disp_word_q[{digit_q, 2'b00} +: 4];
    cur_seg = hexseg(cur_nib);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if (lead_zero(disp_word_q, digit_q)) cur_seg = 7'h00;
`endif

    if (state_q == ST_DRIVE) begin
      enable_d = ~(4'b0001 << digit_q);
      data_d   = ~{disp_dp_q[digit_q], cur_seg};
    end else begin
      enable_d = 4'b1111;
      data_d   = 8'hFF;
    end

    frame_start_d = (slot_q == '0) && (digit_q == 2'd0);
  end

  // State and output registers; synchronous reset restarts the scan at digit 0, slot 0.
  always_ff @(posedge cmosClock) begin
    if (reset) begin
      slot_q        <= '0;
      digit_q       <= 2'd0;
      state_q       <= ST_BLANK;
      disp_word_q   <= 16'h0000;
      disp_dp_q     <= 4'h0;
      pend_word_q   <= 16'h0000;
      pend_dp_q     <= 4'h0;
      pend_full_q   <= 1'b0;
      ready_q       <= 1'b1;
      frame_start_q <= 1'b0;
      enable_q      <= 4'b1111;
      data_q        <= 8'hFF;
    end else begin
      slot_q        <= slot_d;
      digit_q       <= digit_d;
      state_q       <= state_d;
      disp_word_q   <= disp_word_d;
      disp_dp_q     <= disp_dp_d;
      pend_word_q   <= pend_word_d;
      pend_dp_q     <= pend_dp_d;
      pend_full_q   <= pend_full_d;
      ready_q       <= ready_d;
      frame_start_q <= frame_start_d;
      enable_q      <= enable_d;
      data_q        <= data_d;
    end
  end

  assign value_if.valueReady = ready_q;
  assign frameStart          = frame_start_q;
  assign sevenSegmentEnable  = enable_q;
  assign sevenSegmentData    = data_q;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Scoreboard bench for seven_seg_scan_controller with TICK_DIV=8, BLANK_CYCLES=2.
// Stimulus pushes the expected {enable,data} of every digit slot per frame; the monitor
// pops one entry at each start of a DRIVE phase and also checks blanking and anode rules.
module tb_seven_seg_scan_controller;
  localparam int TD = 8;
  localparam int BC = 2;

  logic       cmosClock = 1'b0;
  logic       reset     = 1'b1;
  logic       frameStart;
  logic [3:0] sevenSegmentEnable;
  logic [7:0] sevenSegmentData;

  seven_seg_scan_controller_if vif ();

  seven_seg_scan_controller #(.TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
    .cmosClock          (cmosClock),
    .reset              (reset),
    .value_if           (vif),
    .frameStart         (frameStart),
    .sevenSegmentEnable (sevenSegmentEnable),
    .sevenSegmentData   (sevenSegmentData)
  );

  always #5 cmosClock = ~cmosClock;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];
  bit mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
    exp_q.push_back({4'b1110, d0});
    exp_q.push_back({4'b1101, d1});
    exp_q.push_back({4'b1011, d2});
    exp_q.push_back({4'b0111, d3});
  endtask

  // Hand-computed glyphs (active-low cathodes).
  task automatic push_zero_frame();
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF);
`else
    push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
`endif
  endtask

  task automatic push_0050_frame();
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    push_frame(8'hC0, 8'h92, 8'hFF, 8'hFF);
`else
    push_frame(8'hC0, 8'h92, 8'hC0, 8'hC0);
`endif
  endtask

  // Monitor: scoreboard pop at DRIVE start, blank/anode/stability rules every cycle.
  logic [3:0] prev_en   = 4'hF;
  logic [7:0] prev_data = 8'hFF;
  always @(negedge cmosClock) begin
    logic [11:0] e;
    if (mon_on) begin
      if (sevenSegmentEnable !== 4'hF)
        check("one_anode", $countones(~sevenSegmentEnable), 1);
      else
        check("blank_data", {24'h0, sevenSegmentData}, 32'hFF);
      if (sevenSegmentEnable !== 4'hF && prev_en === 4'hF) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got enable %b data %h expected no drive at %0t",
                   sevenSegmentEnable, sevenSegmentData, $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_enable", {28'h0, sevenSegmentEnable}, {28'h0, e[11:8]});
          check("sb_data", {24'h0, sevenSegmentData}, {24'h0, e[7:0]});
        end
      end else if (sevenSegmentEnable !== 4'hF && sevenSegmentEnable === prev_en) begin
        check("drive_stable", {24'h0, sevenSegmentData}, {24'h0, prev_data});
      end
    end
    prev_en   = sevenSegmentEnable;
    prev_data = sevenSegmentData;
  end

  initial begin
    bit found;
    int n;
    longint t_last;
    vif.valueIn    = 16'h0000;
    vif.dpIn       = 4'h0;
    vif.valueValid = 1'b0;
    reset          = 1'b1;
    push_zero_frame();
    mon_on = 1'b1;

    // Reset held 3 cycles.
    repeat (3) begin
      @(negedge cmosClock);
      check("rst_enable", {28'h0, sevenSegmentEnable}, 32'hF);
      check("rst_data", {24'h0, sevenSegmentData}, 32'hFF);
      check("rst_ready", {31'h0, vif.valueReady}, 1);
      check("rst_frame", {31'h0, frameStart}, 0);
    end
    reset = 1'b0;

    // First slot after release: 2 blank cycles then 6 cycles of digit 0 showing "0".
    for (int c = 0; c < 8; c++) begin
      @(negedge cmosClock);
      check("post_rst_enable", {28'h0, sevenSegmentEnable}, (c < 2) ? 32'hF : 32'hE);
      check("post_rst_data", {24'h0, sevenSegmentData}, (c < 2) ? 32'hFF : 32'hC0);
      check("post_rst_frame", {31'h0, frameStart}, (c == 0) ? 1 : 0);
    end

    // Word 1 mid-frame.
    vif.valueIn    = 16'h1A3F;
    vif.dpIn       = 4'b0100;
    vif.valueValid = 1'b1;
    check("ready_before", {31'h0, vif.valueReady}, 1);
    @(posedge cmosClock);
    push_frame(8'h8E, 8'hB0, 8'h08, 8'hF9);
    #1 vif.valueValid = 1'b0;
    @(negedge cmosClock);
    check("ready_drop", {31'h0, vif.valueReady}, 0);

    // Word 2 held while pending is full; accepted right after the commit.
    vif.valueIn    = 16'h4C8E;
    vif.dpIn       = 4'b0001;
    vif.valueValid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge cmosClock);
      if (vif.valueReady === 1'b1) found = 1'b1;
    end
    check("ready_rise_seen", {31'h0, found}, 1);
    check("ready_rise_before_fs", {31'h0, frameStart}, 0);
    @(posedge cmosClock);
    push_frame(8'h06, 8'h80, 8'hC6, 8'h99);
    #1 vif.valueValid = 1'b0;
    @(negedge cmosClock);
    check("commit_frame_start", {31'h0, frameStart}, 1);
    check("ready_drop2", {31'h0, vif.valueReady}, 0);

    // Wait for the frame showing word 2, then load word 3 into pending.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge cmosClock);
      if (frameStart === 1'b1) found = 1'b1;
    end
    check("fs2_seen", {31'h0, found}, 1);
    check("ready_after_commit", {31'h0, vif.valueReady}, 1);
    vif.valueIn    = 16'h7777;
    vif.dpIn       = 4'hF;
    vif.valueValid = 1'b1;
    @(posedge cmosClock);
    #1 vif.valueValid = 1'b0;
    @(negedge cmosClock);
    check("ready_drop3", {31'h0, vif.valueReady}, 0);

    // Reset pulse during digit-2 DRIVE; pending word 3 must never show.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge cmosClock);
      if (sevenSegmentEnable === 4'b1011) found = 1'b1;
    end
    check("digit2_seen", {31'h0, found}, 1);
    @(negedge cmosClock);
    #1;
    reset = 1'b1;
    exp_q.delete();
    push_zero_frame();
    @(negedge cmosClock);
    check("rst2_enable", {28'h0, sevenSegmentEnable}, 32'hF);
    check("rst2_data", {24'h0, sevenSegmentData}, 32'hFF);
    check("rst2_ready", {31'h0, vif.valueReady}, 1);
    reset = 1'b0;
    @(negedge cmosClock);
    check("rst2_frame_start", {31'h0, frameStart}, 1);
    check("rst2_blank", {28'h0, sevenSegmentEnable}, 32'hF);
    t_last = $time;

    // Word 0050 for the remaining frames.
    vif.valueIn    = 16'h0050;
    vif.dpIn       = 4'h0;
    vif.valueValid = 1'b1;
    @(posedge cmosClock);
    repeat (4) push_0050_frame();
    #1 vif.valueValid = 1'b0;

    // frameStart period over 5 frames.
    n = 0;
    for (int i = 0; i < 200 && n < 5; i++) begin
      @(negedge cmosClock);
      if (frameStart === 1'b1) begin
        check("fs_period", 32'(($time - t_last) / 10), 32);
        t_last = $time;
        n++;
      end
    end
    check("fs_count", n, 5);
    check("sb_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
